// File: rtl/buf8_serout_if.sv
// buf8_serout_if: load port and serial output stream of the 8-deep staging buffer.
interface buf8_serout_if #(parameter int WIDTH = 32);
    logic [WIDTH*8-1:0] inp;
    logic [2:0]         inp_len;
    logic               inp_vld;
    logic               inp_rdy;
    logic [WIDTH-1:0]   o;
    logic [2:0]         o_idx;
    logic               o_last;
    logic               o_vld;
    logic               o_rdy;
    modport master (
        output inp, inp_len, inp_vld, o_rdy,
        input  inp_rdy, o, o_idx, o_last, o_vld
    );
    modport slave (
        input  inp, inp_len, inp_vld, o_rdy,
        output inp_rdy, o, o_idx, o_last, o_vld
    );
endinterface

// File: rtl/buf8_serout.sv
// buf8_serout: captures up to eight elements in one cycle, then emits them
// one per handshake from element 0 on a valid/ready stream.
module buf8_serout #(parameter int WIDTH = 32) (
    input logic          clk,
    input logic          rst,
    buf8_serout_if.slave bus
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t             r_state;
    logic [2:0]         r_ptr;
    logic [2:0]         r_len;
    logic [8*WIDTH-1:0] r_data;
    logic               w_load;
    logic               w_hs;
    assign bus.o_vld   = r_state == SEND;
    assign bus.o_idx   = r_ptr;
    assign bus.o_last  = bus.o_vld & (r_ptr == r_len);
    assign bus.o       = r_data[WIDTH*r_ptr +: WIDTH];
    // Accepting a load on the final handshake keeps bursts back-to-back.
    assign bus.inp_rdy = ~bus.o_vld | (bus.o_rdy & bus.o_last);
    assign w_load      = bus.inp_vld & bus.inp_rdy;
    assign w_hs        = bus.o_vld & bus.o_rdy;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= 3'd0;
            r_len   <= 3'd0;
            r_data  <= '0;
        end else if (w_load) begin
            r_state <= SEND;
            r_ptr   <= 3'd0;
            r_len   <= bus.inp_len;
            r_data  <= bus.inp;
        end else if (w_hs) begin
            r_state <= bus.o_last ? IDLE : SEND;
            r_ptr   <= bus.o_last ? 3'd0 : r_ptr + 3'd1;
        end
    end
endmodule

// File: tb/tb_buf8_serout.sv
// tb_buf8_serout: randomized and directed stimulus; a queue of expected
// elements is checked by a monitor on every falling edge.
module tb_buf8_serout;
    localparam int W = 32;
    typedef struct {
        logic [W-1:0] d;
        logic [2:0]   idx;
        logic         last;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    buf8_serout_if #(.WIDTH(W)) bus();
    buf8_serout #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    item_t q[$];
    int checks = 0;
    int passed = 0;
    int vld_cycles = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a load enqueues elements 0..len; each handshake dequeues one.
    always @(negedge clk) begin
        logic exp_rdy;
        if (rst) begin
            q.delete();
            chk("rst_o_vld", bus.o_vld, 0);
            chk("rst_o_last", bus.o_last, 0);
            chk("rst_o_idx", bus.o_idx, 0);
            chk("rst_o", bus.o, 0);
            chk("rst_inp_rdy", bus.inp_rdy, 1);
        end else begin
            exp_rdy = q.size() == 0 || (bus.o_rdy && q[0].last);
            chk("o_vld", bus.o_vld, q.size() != 0);
            chk("inp_rdy", bus.inp_rdy, exp_rdy);
            if (q.size() != 0) begin
                vld_cycles++;
                chk("o", bus.o, q[0].d);
                chk("o_idx", bus.o_idx, q[0].idx);
                chk("o_last", bus.o_last, q[0].last);
                if (bus.o_rdy) void'(q.pop_front());
            end else begin
                chk("o_last_idle", bus.o_last, 0);
            end
            if (bus.inp_vld && exp_rdy)
                for (int i = 0; i <= int'(bus.inp_len); i++)
                    q.push_back('{bus.inp[W*i +: W], 3'(i), i == int'(bus.inp_len)});
        end
    end

    function automatic logic [8*W-1:0] seq(input logic [W-1:0] base);
        logic [8*W-1:0] v;
        for (int i = 0; i < 8; i++) v[W*i +: W] = base + W'(i);
        return v;
    endfunction

    function automatic logic [8*W-1:0] rnd_word();
        logic [8*W-1:0] v;
        for (int i = 0; i < 8; i++) v[W*i +: W] = $urandom;
        return v;
    endfunction

    task automatic issue(input logic [8*W-1:0] d, input logic [2:0] len);
        bus.inp     = d;
        bus.inp_len = len;
        bus.inp_vld = 1'b1;
    endtask

    // Holds the request until accepted, then returns #1 after the load edge.
    task automatic accept();
        bit ok = 0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            ok = bus.inp_rdy;
        end
        if (!ok) begin
            checks++;
            $display("FAIL accept_timeout: inp_rdy never rose");
        end
        @(posedge clk); #1;
        bus.inp_vld = 1'b0;
        bus.inp     = rnd_word();
        bus.inp_len = 3'($urandom);
    endtask

    task automatic drain();
        int c = 0;
        while (q.size() != 0 && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: %0d items left", q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [9:0] pat;
        logic       acc;
        bus.inp     = rnd_word();
        bus.inp_len = 3'($urandom);
        bus.inp_vld = 1'($urandom);
        bus.o_rdy   = 1'($urandom);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        bus.inp_vld = 1'b0;
        bus.o_rdy   = 1'b1;
        rst         = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_o", bus.o, 0);
        end
        @(posedge clk); #1;

        // full burst
        vld_cycles = 0;
        issue(seq(32'h10), 3'd7);
        accept();
        drain();
        chk("full_vld_cycles", vld_cycles, 8);

        // backpressure
        pat = 10'b1111101001;
        vld_cycles = 0;
        issue(seq(32'h10), 3'd7);
        accept();
        for (int k = 0; k < 10; k++) begin
            bus.o_rdy   = pat[k];
            bus.inp_len = 3'($urandom);
            @(posedge clk); #1;
        end
        bus.o_rdy = 1'b1;
        drain();
        chk("bp_vld_cycles", vld_cycles, 11);

        // short burst
        vld_cycles = 0;
        issue({rnd_word() >> W, 32'hAA}, 3'd0);
        accept();
        drain();
        chk("short_vld_cycles", vld_cycles, 1);

        // back-to-back: second request held from mid-burst until the last handshake
        vld_cycles = 0;
        issue(seq(32'h10), 3'd7);
        accept();
        issue(seq(32'h20), 3'd2);
        accept();
        drain();
        chk("b2b_vld_cycles", vld_cycles, 11);

        // mid-burst asynchronous reset
        issue(seq(32'h40), 3'd7);
        accept();
        begin
            bit hit = 0;
            for (int c = 0; c < 20 && !hit; c++) begin
                @(negedge clk);
                hit = bus.o_idx == 3'd3;
            end
            chk("reach_idx3", hit, 1);
        end
        #1 rst = 1'b1;
        #1;
        chk("async_o_vld", bus.o_vld, 0);
        chk("async_o_idx", bus.o_idx, 0);
        chk("async_inp_rdy", bus.inp_rdy, 1);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        vld_cycles = 0;
        issue(seq(32'h50), 3'd1);
        accept();
        drain();
        chk("post_rst_vld_cycles", vld_cycles, 2);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            acc = bus.inp_vld & bus.inp_rdy;
            @(posedge clk); #1;
            bus.o_rdy = $urandom_range(0, 3) != 0;
            if (acc || !bus.inp_vld) begin
                bus.inp_vld = $urandom_range(0, 2) == 0;
                bus.inp     = rnd_word();
                bus.inp_len = 3'($urandom);
            end
        end
        bus.inp_vld = 1'b0;
        bus.o_rdy   = 1'b1;
        drain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
